// File: rtl/multi_delay.sv
// Multi-channel programmable delay: each channel pulses o_cnt every mod enabled edges.
// Optional per-channel saturating pulse counter on o_pulse_cnt when MULTI_DELAY_PULSE_CNT_EN is defined.
module multi_delay #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic [CHANNELS-1:0]   i_count_enbl,
    input  logic                  i_set_module_enbl,
    input  logic [SEL_W-1:0]      i_chan_sel,
    input  logic [WIDTH-1:0]      i_module,
    input  logic                  i_mode,
    input  logic [CHANNELS-1:0]   i_rearm,
    output logic [CHANNELS-1:0]   o_cnt,
    output logic [CHANNELS-1:0]   o_busy
`ifdef MULTI_DELAY_PULSE_CNT_EN
    ,
    output logic [8*CHANNELS-1:0] o_pulse_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

    logic [WIDTH-1:0]    mod_q   [CHANNELS];
    logic [WIDTH-1:0]    mod_d   [CHANNELS];
    logic [WIDTH-1:0]    cnt_q   [CHANNELS];
    logic [WIDTH-1:0]    cnt_d   [CHANNELS];
    state_e              state_q [CHANNELS];
    state_e              state_d [CHANNELS];
    logic [CHANNELS-1:0] mode_q, mode_d;
    logic [CHANNELS-1:0] pulse_q, pulse_d;
    logic [CHANNELS-1:0] load_hit;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            // Out-of-range selects never match any channel index.
            load_hit[c] = i_set_module_enbl && (int'(i_chan_sel) == c);
            mod_d[c]    = mod_q[c];
            mode_d[c]   = mode_q[c];
            cnt_d[c]    = cnt_q[c];
            state_d[c]  = state_q[c];
            pulse_d[c]  = 1'b0;
            if (load_hit[c]) begin
                mod_d[c]   = i_module;
                mode_d[c]  = i_mode;
                cnt_d[c]   = '0;
                state_d[c] = (i_module == '0) ? StIdle : StRun;
            end else begin
                case (state_q[c])
                    StRun: begin
                        if (i_count_enbl[c]) begin
                            if (cnt_q[c] == mod_q[c] - CntOne) begin
                                cnt_d[c]   = '0;
                                pulse_d[c] = 1'b1;
                                if (mode_q[c]) begin
                                    state_d[c] = StDone;
                                end
                            end else begin
                                cnt_d[c] = cnt_q[c] + CntOne;
                            end
                        end
                    end
                    StDone: begin
                        if (i_rearm[c]) begin
                            state_d[c] = StRun;
                            cnt_d[c]   = '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                mod_q[c]   <= '0;
                cnt_q[c]   <= '0;
                state_q[c] <= StIdle;
            end
            mode_q  <= '0;
            pulse_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                mod_q[c]   <= mod_d[c];
                cnt_q[c]   <= cnt_d[c];
                state_q[c] <= state_d[c];
            end
            mode_q  <= mode_d;
            pulse_q <= pulse_d;
        end
    end

    assign o_cnt = pulse_q;

    always_comb begin
        o_busy = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            o_busy[c] = (state_q[c] == StRun);
        end
    end

`ifdef MULTI_DELAY_PULSE_CNT_EN
    logic [7:0] pcnt_q [CHANNELS];
    logic [7:0] pcnt_d [CHANNELS];

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            pcnt_d[c] = pcnt_q[c];
            if (load_hit[c]) begin
                pcnt_d[c] = '0;
            end else if (pulse_d[c] && (pcnt_q[c] != 8'hFF)) begin
                pcnt_d[c] = pcnt_q[c] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (i_rst) begin
                pcnt_q[c] <= '0;
            end else begin
                pcnt_q[c] <= pcnt_d[c];
            end
        end
    end

    always_comb begin
        o_pulse_cnt = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            o_pulse_cnt[8*c +: 8] = pcnt_q[c];
        end
    end
`endif

endmodule

// File: tb/tb_multi_delay.sv
// Scoreboard bench for multi_delay: a countdown reference model queues expected outputs per edge.
module tb_multi_delay;

    localparam int W  = 4;
    localparam int CH = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] en, rearm;
    logic          ld;
    logic [SW-1:0] sel;
    logic [W-1:0]  modv;
    logic          mode;
    logic [CH-1:0] o_cnt, o_busy;
    logic [2:0]    o_cnt3, o_busy3;
`ifdef MULTI_DELAY_PULSE_CNT_EN
    logic [8*CH-1:0] pcnt;
    logic [23:0]     pcnt3;
`endif

    int checks = 0;
    int errors = 0;

    int m_mod [CH];
    int m_mode[CH];
    int m_rem [CH];
    int m_st  [CH];  // 0 idle, 1 run, 2 done
    int m_pc  [CH];
    logic [2*CH-1:0] exp_q[$];
    logic [15:0] rec;

    always #5 clk = ~clk;

    multi_delay #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) u_dut (
        .clk              (clk),
        .i_rst            (rst),
        .i_count_enbl     (en),
        .i_set_module_enbl(ld),
        .i_chan_sel       (sel),
        .i_module         (modv),
        .i_mode           (mode),
        .i_rearm          (rearm),
        .o_cnt            (o_cnt),
        .o_busy           (o_busy)
`ifdef MULTI_DELAY_PULSE_CNT_EN
        ,
        .o_pulse_cnt      (pcnt)
`endif
    );

    // Three channels so that select value 3 is out of range.
    multi_delay #(.WIDTH(W), .CHANNELS(3), .SEL_W(SW)) u_dut3 (
        .clk              (clk),
        .i_rst            (rst),
        .i_count_enbl     (en[2:0]),
        .i_set_module_enbl(ld),
        .i_chan_sel       (sel),
        .i_module         (modv),
        .i_mode           (mode),
        .i_rearm          (rearm[2:0]),
        .o_cnt            (o_cnt3),
        .o_busy           (o_busy3)
`ifdef MULTI_DELAY_PULSE_CNT_EN
        ,
        .o_pulse_cnt      (pcnt3)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [CH-1:0] p, b;
        p = '0;
        b = '0;
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                m_mod[c] = 0; m_mode[c] = 0; m_rem[c] = 0; m_st[c] = 0; m_pc[c] = 0;
            end else if (ld && int'(sel) == c) begin
                m_mod[c]  = int'(modv);
                m_mode[c] = int'(mode);
                m_rem[c]  = int'(modv);
                m_st[c]   = (modv == 0) ? 0 : 1;
                m_pc[c]   = 0;
            end else if (m_st[c] == 1 && en[c]) begin
                m_rem[c]--;
                if (m_rem[c] == 0) begin
                    p[c]     = 1'b1;
                    m_rem[c] = m_mod[c];
                    if (m_mode[c] == 1) m_st[c] = 2;
                    if (m_pc[c] < 255) m_pc[c]++;
                end
            end else if (m_st[c] == 2 && rearm[c]) begin
                m_st[c]  = 1;
                m_rem[c] = m_mod[c];
            end
            b[c] = (m_st[c] == 1);
        end
        exp_q.push_back({p, b});
    endtask

    task automatic tick();
        logic [2*CH-1:0] e;
        model_step();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq("sb_cnt", 32'(o_cnt), 32'(e[2*CH-1:CH]));
            check_eq("sb_busy", 32'(o_busy), 32'(e[CH-1:0]));
`ifdef MULTI_DELAY_PULSE_CNT_EN
            for (int c = 0; c < CH; c++) check_eq("sb_pcnt", 32'(pcnt[8*c +: 8]), 32'(m_pc[c]));
`endif
        end
    endtask

    task automatic load(input int ch, input int m, input logic md);
        ld = 1'b1; sel = SW'(ch); modv = W'(m); mode = md;
        tick();
        ld = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = '0; rearm = '0; ld = 1'b0; sel = '0; modv = '0; mode = 1'b0;
        tick();
        tick();
        check_eq("reset_cnt", 32'(o_cnt), 32'd0);
        check_eq("reset_busy", 32'(o_busy), 32'd0);
        rst = 1'b0;

        // ch0 mod=3 periodic: pulses after enabled edges 3, 6, 9.
        load(0, 3, 1'b0);
        en = 4'b0001; rec = '0;
        for (int i = 0; i < 9; i++) begin
            tick();
            rec[i] = o_cnt[0];
            check_eq("t1_others", 32'(o_cnt[3:1]), 32'd0);
        end
        check_eq("t1_pulses", 32'(rec[8:0]), 32'b100100100);
        en = '0;

        // ch1 mod=4 one-shot, then rearm.
        load(1, 4, 1'b1);
        en = 4'b0010; rec = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            rec[i] = o_cnt[1];
        end
        check_eq("t2_oneshot", 32'(rec[9:0]), 32'b0000001000);
        check_eq("t2_done_busy", 32'(o_busy[1]), 32'd0);
        en = '0; rearm = 4'b0010;
        tick();
        check_eq("t2_rearm_busy", 32'(o_busy[1]), 32'd1);
        rearm = '0; en = 4'b0010; rec = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            rec[i] = o_cnt[1];
        end
        check_eq("t2_rearm_pulse", 32'(rec[3:0]), 32'b1000);
        en = '0;

        // ch2 mod=5 with enable toggling every other cycle.
        load(2, 5, 1'b0);
        rec = '0;
        for (int i = 0; i < 10; i++) begin
            en = (i % 2 == 0) ? 4'b0100 : 4'b0000;
            tick();
            rec[i] = o_cnt[2];
        end
        check_eq("t3_gapped", 32'(rec[9:0]), 32'b0100000000);
        en = '0;

        // ch3 mod=6, reload with mod=2 at cnt=4.
        load(3, 6, 1'b0);
        en = 4'b1000;
        for (int i = 0; i < 4; i++) tick();
        load(3, 2, 1'b0);
        check_eq("t4_load_no_pulse", 32'(o_cnt[3]), 32'd0);
        rec = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            rec[i] = o_cnt[3];
        end
        check_eq("t4_reload_pulses", 32'(rec[3:0]), 32'b1010);
        en = '0;

        // mod=1 pulses on every enabled cycle.
        load(0, 1, 1'b0);
        en = 4'b0001; rec = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            rec[i] = o_cnt[0];
        end
        check_eq("t5_mod1", 32'(rec[4:0]), 32'b11111);
        en = '0;

        // Full-range modulus.
        load(1, 15, 1'b0);
        en = 4'b0010; rec = '0;
        for (int i = 0; i < 16; i++) begin
            tick();
            rec[i] = o_cnt[1];
        end
        check_eq("t6_fullrange", 32'(rec), 32'h4000);
        en = '0;

        // Reset with ch0 at cnt=mod-1, while loads, rearms and enables are active.
        load(0, 3, 1'b0);
        en = 4'b0001;
        tick();
        tick();
        rst = 1'b1; ld = 1'b1; sel = 2'd1; modv = 4'd4; rearm = '1; en = '1;
        tick();
        check_eq("t7_rst_cnt", 32'(o_cnt), 32'd0);
        check_eq("t7_rst_busy", 32'(o_busy), 32'd0);
        check_eq("t7_rst_cnt3", 32'(o_cnt3), 32'd0);
        rst = 1'b0; ld = 1'b0; rearm = '0;

        // Out-of-range select on the 3-channel instance.
        load(3, 5, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("t8_oor_cnt3", 32'(o_cnt3), 32'd0);
            check_eq("t8_oor_busy3", 32'(o_busy3), 32'd0);
        end

        // Load with mod=0 leaves the channel idle.
        load(0, 0, 1'b0);
        check_eq("t9_mod0_busy", 32'(o_busy[0]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t9_mod0_cnt", 32'(o_cnt[0]), 32'd0);
        end
        en = '0;

`ifdef MULTI_DELAY_PULSE_CNT_EN
        load(0, 1, 1'b0);
        en = 4'b0001;
        for (int i = 0; i < 300; i++) tick();
        check_eq("t10_pcnt_sat", 32'(pcnt[7:0]), 32'd255);
        en = '0;
`endif

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
